// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer
//   Front end for the repeated-addition multiplier. Operand pairs from a
//   producer are queued in a small FIFO and handed to the multiplier one at a
//   time: each pair gets a one-cycle start pulse, then the sequencer waits for
//   the multiplier's done pulse before issuing the next pair. Completed jobs
//   are counted, and a watchdog abandons a job whose done pulse never comes.
//
//   state | meaning
//   IDLE  | nothing in flight; pops the FIFO head as soon as one is queued
//   ISSUE | start pulse high for exactly one cycle, operands stable
//   WAIT  | waiting for mul_v_i; watchdog counts cycles spent here
//
// Ports
//   clock_i        sole clock, rising edge
//   reset_i        synchronous, active-high
//   push_i         producer offers {push_a_i, push_b_i} this cycle
//   push_a_i/b_i   operand pair (A -> mul_in1_o, B -> mul_in2_o)
//   full_o/empty_o FIFO occupancy flags
//   mul_in1_o/2_o  registered operands, hold the last issued pair
//   mul_s_o        registered start pulse to the multiplier
//   mul_v_i        done pulse from the multiplier
//   busy_o         high while in ISSUE or WAIT
//   jobs_done_o    completed-job counter, wraps
//   timeout_err_o  sticky watchdog flag, cleared only by reset
module mul_operand_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        push_i,
  input  logic [31:0] push_a_i,
  input  logic [31:0] push_b_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [31:0] mul_in1_o,
  output logic [31:0] mul_in2_o,
  output logic        mul_s_o,
  input  logic        mul_v_i,
  output logic        busy_o,
  output logic [15:0] jobs_done_o,
  output logic        timeout_err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [15:0]   WDOG_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   in1_q, in1_d;
  logic [31:0]   in2_q, in2_d;
  logic          mul_s_q, mul_s_d;
  logic [15:0]   wdog_q, wdog_d;
  logic [15:0]   jobs_done_q, jobs_done_d;
  logic          timeout_err_q, timeout_err_d;
  logic [63:0]   mem_q [DEPTH];

  logic push_ok;
  logic pop;

  assign full_o        = (count_q == COUNT_FULL);
  assign empty_o       = (count_q == '0);
  assign mul_in1_o     = in1_q;
  assign mul_in2_o     = in2_q;
  assign mul_s_o       = mul_s_q;
  assign busy_o        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign jobs_done_o   = jobs_done_q;
  assign timeout_err_o = timeout_err_q;

  // Room is judged on the pre-edge count, so a same-edge pop never frees a slot.
  assign push_ok = push_i && !full_o;
  assign pop     = (state_q == ST_IDLE) && !empty_o;

  always_comb begin
    state_d       = state_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    mul_s_d       = 1'b0;
    wdog_d        = wdog_q;
    jobs_done_d   = jobs_done_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty_o) begin
          in1_d   = mem_q[rd_ptr_q][63:32];
          in2_d   = mem_q[rd_ptr_q][31:0];
          mul_s_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done pulse wins over watchdog expiry on the same edge.
        if (mul_v_i) begin
          jobs_done_d = jobs_done_q + 16'd1;
          state_d     = ST_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in1_q         <= '0;
      in2_q         <= '0;
      mul_s_q       <= 1'b0;
      wdog_q        <= '0;
      jobs_done_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      mul_s_q       <= mul_s_d;
      wdog_q        <= wdog_d;
      jobs_done_q   <= jobs_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clock_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {push_a_i, push_b_i};
    end
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Bench for mul_operand_sequencer. A queue-based reference model tracks the
// FIFO contents, the issue/wait phase and the counters; the bench plays the
// multiplier itself, answering each start pulse after a chosen latency.
module tb_mul_operand_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        push_i = 1'b0;
  logic [31:0] push_a_i = '0;
  logic [31:0] push_b_i = '0;
  logic        mul_v_i = 1'b0;
  logic        full_o, empty_o, mul_s_o, busy_o, timeout_err_o;
  logic [31:0] mul_in1_o, mul_in2_o;
  logic [15:0] jobs_done_o;

  always #5 clock_i = ~clock_i;

  mul_operand_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .push_i(push_i),
    .push_a_i(push_a_i), .push_b_i(push_b_i),
    .full_o(full_o), .empty_o(empty_o),
    .mul_in1_o(mul_in1_o), .mul_in2_o(mul_in2_o),
    .mul_s_o(mul_s_o), .mul_v_i(mul_v_i), .busy_o(busy_o),
    .jobs_done_o(jobs_done_o), .timeout_err_o(timeout_err_o)
  );

  // reference model: ph 0 = idle, 1 = start pulse cycle, 2 = awaiting done
  logic [63:0] q[$];
  int          ph = 0;
  int          w = 0;
  logic [15:0] m_jobs = '0;
  logic        m_terr = 1'b0;
  logic        m_s = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit rst, input bit p, input logic [31:0] a,
                      input logic [31:0] b, input bit v);
    bit acc;
    @(negedge clock_i);
    reset_i  = rst;
    push_i   = p;
    push_a_i = a;
    push_b_i = b;
    mul_v_i  = v;
    @(posedge clock_i);
    if (rst) begin
      q.delete();
      ph = 0; w = 0; m_jobs = '0; m_terr = 1'b0; m_s = 1'b0; m_a = '0; m_b = '0;
    end else begin
      acc = p && (q.size() < DEPTH);
      case (ph)
        0: if (q.size() > 0) begin
             {m_a, m_b} = q.pop_front();
             m_s = 1'b1;
             ph = 1;
           end
        1: begin m_s = 1'b0; w = 0; ph = 2; end
        default: begin
          if (v) begin m_jobs = m_jobs + 16'd1; ph = 0; end
          else if (w == TO - 1) begin m_terr = 1'b1; ph = 0; end
          else w++;
        end
      endcase
      if (acc) q.push_back({a, b});
    end
    #1;
    chk("full", full_o, q.size() == DEPTH);
    chk("empty", empty_o, q.size() == 0);
    chk("mul_s", mul_s_o, m_s);
    chk("mul_in1", mul_in1_o, m_a);
    chk("mul_in2", mul_in2_o, m_b);
    chk("busy", busy_o, ph != 0);
    chk("jobs_done", jobs_done_o, m_jobs);
    chk("timeout_err", timeout_err_o, m_terr);
  endtask

  // idle cycles, with the bench answering as a multiplier of latency lat
  task automatic run(input int n, input bit v_en, input int lat);
    for (int i = 0; i < n; i++) tick(0, 0, '0, '0, v_en && ph == 2 && w == lat);
  endtask

  int  cnt;
  int  lat;
  bit  ven;
  bit  v;

  initial begin
    // reset state
    tick(1, 0, '0, '0, 0);
    tick(0, 0, '0, '0, 0);

    // single job: (3,5)
    tick(0, 1, 32'd3, 32'd5, 0);
    chk("lat_s_low_after_push", mul_s_o, 1'b0);
    tick(0, 0, '0, '0, 0);
    chk("lat_s_high", mul_s_o, 1'b1);
    chk("lat_in1", mul_in1_o, 32'd3);
    chk("lat_in2", mul_in2_o, 32'd5);
    run(6, 1, 2);
    chk("job1_done", jobs_done_o, 16'd1);
    chk("job1_idle", busy_o, 1'b0);

    // back-to-back pushes, one more than fits
    tick(0, 1, 32'd2, 32'd7, 0);
    tick(0, 1, 32'd0, 32'd9, 0);
    tick(0, 1, 32'd6, 32'd6, 0);
    tick(0, 1, 32'd1, 32'd1, 0);
    tick(0, 1, 32'd4, 32'd4, 0);
    chk("fill_full", full_o, 1'b1);
    tick(0, 1, 32'd8, 32'd8, 0);
    chk("drop_full", full_o, 1'b1);
    run(40, 1, 3);
    chk("burst_jobs", jobs_done_o, 16'd6);
    chk("burst_empty", empty_o, 1'b1);

    // watchdog: no done pulse at all
    tick(0, 1, 32'd11, 32'd12, 0);
    tick(0, 0, '0, '0, 0);
    chk("wd_issue", mul_s_o, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20 && !timeout_err_o; i++) begin
      tick(0, 0, '0, '0, 0);
      if (busy_o && !mul_s_o) cnt++;
    end
    chk("wd_wait_cycles", cnt, 8);
    chk("wd_flag", timeout_err_o, 1'b1);
    chk("wd_jobs", jobs_done_o, 16'd6);
    chk("wd_idle", busy_o, 1'b0);
    tick(0, 1, 32'd13, 32'd14, 0);
    run(8, 1, 1);
    chk("wd_next_job", jobs_done_o, 16'd7);
    chk("wd_sticky", timeout_err_o, 1'b1);

    // reset while waiting with pairs queued, then a stray done pulse
    tick(0, 1, 32'd21, 32'd22, 0);
    tick(0, 1, 32'd23, 32'd24, 0);
    tick(0, 1, 32'd25, 32'd26, 0);
    tick(0, 0, '0, '0, 0);
    chk("rst_pre_wait", busy_o, 1'b1);
    tick(1, 0, '0, '0, 0);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_in1", mul_in1_o, 32'd0);
    tick(0, 0, '0, '0, 1);
    run(3, 0, 0);
    chk("rst_stray_v", jobs_done_o, 16'd0);

    // counter wrap
    @(negedge clock_i);
    force dut.jobs_done_q = 16'hFFFF;
    m_jobs = 16'hFFFF;
    tick(0, 0, '0, '0, 0);
    release dut.jobs_done_q;
    tick(0, 1, 32'd9, 32'd9, 0);
    run(8, 1, 0);
    chk("wrap", jobs_done_o, 16'h0000);

    // random traffic
    lat = 0;
    ven = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (ph == 1) begin
        lat = $urandom_range(0, TO - 1);
        ven = ($urandom_range(0, 5) != 0);
      end
      if (ph == 2) v = ven && (w == lat);
      else         v = ($urandom_range(0, 7) == 0);
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
           $urandom, $urandom, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
